// File: rtl/ifu_fetch_if.sv
// Fetch-side bundle: im address/instruction, IF/ID handoff to decode, execute redirect.
// master = fetch unit (initiator of im, producer of IF/ID); slave = its environment.
interface ifu_fetch_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_instr;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;

    logic              redir_valid;
    logic [1:0]        redir_type;
    logic [31:0]       redir_pc4;
    logic [15:0]       redir_off;
    logic [25:0]       redir_index;
    logic [31:0]       redir_reg;

    modport master (
        output im_addr,
        input  im_instr,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        input  redir_valid, redir_type, redir_pc4, redir_off, redir_index, redir_reg
    );

    modport slave (
        input  im_addr,
        output im_instr,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        output redir_valid, redir_type, redir_pc4, redir_off, redir_index, redir_reg
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC -> im -> IF/ID register, 1-cycle latency, 1 instr/cycle.
// Backpressure: a full IF/ID register holds PC and instruction until decode is ready; redirect flushes it.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus,
    output logic         misalign_err,
    output logic [31:0]  fetch_count
);
    localparam logic [1:0] RT_BRANCH = 2'b00;
    localparam logic [1:0] RT_J      = 2'b01;
    localparam logic [1:0] RT_JR     = 2'b10;

    typedef enum logic {EMPTY, FULL} ifid_state_t;

    ifid_state_t state;
    logic [31:0] pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] target;
    logic        fetch;
    logic        accept;
    logic        jr_misaligned;

    assign fetch         = !bus.redir_valid && ((state == EMPTY) || bus.out_ready);
    assign accept        = (state == FULL) && bus.out_ready && !bus.redir_valid;
    assign jr_misaligned = (bus.redir_type == RT_JR) && (bus.redir_reg[1:0] != 2'b00);

    always_comb begin
        target = RESET_PC;
        case (bus.redir_type)
            RT_BRANCH: target = bus.redir_pc4 + {{14{bus.redir_off[15]}}, bus.redir_off, 2'b00};
            RT_J:      target = {bus.redir_pc4[31:28], bus.redir_index, 2'b00};
            RT_JR:     target = {bus.redir_reg[31:2], 2'b00};
            default:   target = RESET_PC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            pc           <= RESET_PC;
            out_instr    <= 32'h0;
            out_pc       <= 32'h0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else if (bus.redir_valid) begin
            // Flush wins over any pending handoff; the dropped instruction is never counted.
            state <= EMPTY;
            pc    <= target;
            if (jr_misaligned) begin
                misalign_err <= 1'b1;
            end
        end else begin
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (fetch) begin
                state     <= FULL;
                out_instr <= bus.im_instr;
                out_pc    <= pc;
                pc        <= pc + 32'd4;
            end
        end
    end

    assign bus.im_addr   = pc[ADDR_W+1:2];
    assign bus.out_valid = (state == FULL);
    assign bus.out_instr = out_instr;
    assign bus.out_pc    = out_pc;
endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboarded bench for ifu_fetch: im word k returns 0x1000_0000+k, fetched PCs queued and checked on handoff.
module tb_ifu_fetch;
    localparam int          ADDR_W   = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic        m_mis;
    logic [31:0] exp_q[$];

    ifu_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    ifu_fetch #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    assign bus.im_instr = 32'h1000_0000 + {{(32-ADDR_W){1'b0}}, bus.im_addr};

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 + {{(32-ADDR_W){1'b0}}, a[ADDR_W+1:2]};
    endfunction

    function automatic logic [31:0] redir_target();
        logic [31:0] t;
        t = RESET_PC;
        case (bus.redir_type)
            2'b00:   t = bus.redir_pc4 + ({{16{bus.redir_off[15]}}, bus.redir_off} << 2);
            2'b01:   t = {bus.redir_pc4[31:28], bus.redir_index, 2'b00};
            2'b10:   t = bus.redir_reg & 32'hFFFF_FFFC;
            default: t = RESET_PC;
        endcase
        return t;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_redir(input logic [1:0] t, input logic [31:0] pc4, input logic [15:0] off,
                             input logic [25:0] idx, input logic [31:0] r);
        bus.redir_valid = 1'b1;
        bus.redir_type  = t;
        bus.redir_pc4   = pc4;
        bus.redir_off   = off;
        bus.redir_index = idx;
        bus.redir_reg   = r;
    endtask

    // One clock: pop on handoff, advance the model, then check at the following negedge.
    task automatic tick();
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            m_pc = RESET_PC; m_valid = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
        end else if (bus.redir_valid) begin
            exp_q.delete();
            if (bus.redir_type == 2'b10 && bus.redir_reg[1:0] != 2'b00) m_mis = 1'b1;
            m_pc = redir_target();
            m_valid = 1'b0;
        end else begin
            if (m_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_eq("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("acc_pc", bus.out_pc, e);
                    chk_eq("acc_instr", bus.out_instr, word_at(e));
                end
                m_cnt = m_cnt + 32'd1;
            end
            if (!m_valid || bus.out_ready) begin
                exp_q.push_back(m_pc);
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk_eq("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
        chk_eq("fetch_count", fetch_count, m_cnt);
        chk_eq("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        chk_eq("im_addr", {24'b0, bus.im_addr}, {24'b0, m_pc[ADDR_W+1:2]});
        if (m_valid && exp_q.size() != 0) chk_eq("head_pc", bus.out_pc, exp_q[0]);
    endtask

    initial begin
        logic [31:0] snap;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        set_redir(2'b00, 32'h0, 16'h0, 26'h0, 32'h0);
        bus.redir_valid = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk_eq("rst_instr", bus.out_instr, 32'd0);
        chk_eq("rst_pc", bus.out_pc, 32'd0);
        chk_eq("rst_cnt", fetch_count, 32'd0);
        chk_eq("rst_addr", {24'b0, bus.im_addr}, 32'd0);

        // Free run
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk_eq("first_pc", bus.out_pc, 32'd0);
        chk_eq("first_instr", bus.out_instr, 32'h1000_0000);
        repeat (5) tick();
        chk_eq("cnt5", fetch_count, 32'd5);

        // Restart, then stall with out_pc=8
        set_redir(2'b11, 32'h0, 16'h0, 26'h0, 32'h0);
        tick();
        bus.redir_valid = 1'b0;
        chk_eq("restart_addr", {24'b0, bus.im_addr}, 32'd0);
        repeat (3) tick();
        chk_eq("pre_stall_pc", bus.out_pc, 32'd8);
        bus.out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk_eq("stall_pc", bus.out_pc, 32'd8);
            chk_eq("stall_instr", bus.out_instr, 32'h1000_0002);
            chk_eq("stall_addr", {24'b0, bus.im_addr}, 32'd3);
        end
        bus.out_ready = 1'b1;
        tick();
        chk_eq("post_stall_pc", bus.out_pc, 32'd12);

        // Backward branch to 0x08
        set_redir(2'b00, 32'h10, 16'hFFFE, 26'h0, 32'h0);
        tick();
        bus.redir_valid = 1'b0;
        chk_eq("br_bubble", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk_eq("br_pc", bus.out_pc, 32'h8);
        chk_eq("br_instr", bus.out_instr, 32'h1000_0002);

        // j
        set_redir(2'b01, 32'h3000_0004, 16'h0, 26'h40, 32'h0);
        tick();
        bus.redir_valid = 1'b0;
        chk_eq("j_addr", {24'b0, bus.im_addr}, 32'h40);
        tick();
        chk_eq("j_pc", bus.out_pc, 32'h3000_0100);
        chk_eq("j_instr", bus.out_instr, 32'h1000_0040);

        // Misaligned jr
        set_redir(2'b10, 32'h0, 16'h0, 26'h0, 32'h0000_0022);
        tick();
        bus.redir_valid = 1'b0;
        chk_eq("jr_addr", {24'b0, bus.im_addr}, 32'h8);
        chk_eq("jr_mis", {31'b0, misalign_err}, 32'd1);
        repeat (3) tick();
        chk_eq("jr_mis_sticky", {31'b0, misalign_err}, 32'd1);
        chk_eq("jr_pc", bus.out_pc, 32'h28);

        // Back-to-back redirects keep the register empty
        set_redir(2'b00, 32'h100, 16'h0, 26'h0, 32'h0);
        tick();
        tick();
        chk_eq("dbl_bubble", {31'b0, bus.out_valid}, 32'd0);
        bus.redir_valid = 1'b0;
        tick();
        chk_eq("dbl_pc", bus.out_pc, 32'h100);

        // Redirect during stall, then im_addr wrap
        bus.out_ready = 1'b0;
        tick();
        snap = m_cnt;
        set_redir(2'b00, 32'h0, 16'h00FF, 26'h0, 32'h0);
        tick();
        bus.redir_valid = 1'b0;
        chk_eq("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk_eq("flush_cnt", fetch_count, snap);
        chk_eq("wrap_addr_ff", {24'b0, bus.im_addr}, 32'hFF);
        bus.out_ready = 1'b1;
        tick();
        chk_eq("wrap_addr_00", {24'b0, bus.im_addr}, 32'h0);
        chk_eq("wrap_pc", bus.out_pc, 32'h3FC);
        chk_eq("wrap_instr", bus.out_instr, 32'h1000_00FF);
        tick();
        chk_eq("wrap_next_pc", bus.out_pc, 32'h400);
        chk_eq("wrap_next_instr", bus.out_instr, 32'h1000_0000);

        // Random backpressure
        repeat (40) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.out_ready = 1'b1;

        // Reset together with a redirect
        set_redir(2'b01, 32'h3000_0004, 16'h0, 26'h55, 32'h0);
        rst = 1'b1;
        tick();
        chk_eq("rr_valid", {31'b0, bus.out_valid}, 32'd0);
        chk_eq("rr_cnt", fetch_count, 32'd0);
        chk_eq("rr_addr", {24'b0, bus.im_addr}, RESET_PC >> 2);
        chk_eq("rr_mis", {31'b0, misalign_err}, 32'd0);
        rst = 1'b0;
        bus.redir_valid = 1'b0;
        tick();
        chk_eq("rr_first_pc", bus.out_pc, RESET_PC);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
